// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//
// Shares the single physical-memory port between the I-cache and the D-cache
// line-miss engines of the pipelined LC-3b. A winning request is latched in
// IDLE. Memory is then driven from that latched copy until pmem_resp, and the
// response is routed only to the requester that won. D normally has priority.
// A saturating streak counter forces an I grant after MAX_D_BURST consecutive
// D grants taken while I was waiting, so I can never starve.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   i_pmem_read/_address     I-cache line read request
//   i_pmem_rdata/_resp       line data / completion pulse back to the I-cache
//   d_pmem_read/_write       D-cache line read / writeback request
//   d_pmem_address/_wdata    D-cache line address / writeback data
//   d_pmem_rdata/_resp       line data / completion pulse back to the D-cache
//   pmem_read/_write         physical memory command (registered sources)
//   pmem_address/_wdata      physical memory address / write data
//   pmem_rdata/_resp         physical memory read data / 1-cycle done pulse
//   arb_state                00 IDLE, 01 SERVE_I, 10 SERVE_D (perf/debug)
// -----------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int MAX_D_BURST = 4,
  parameter int LINE_W      = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [15:0]       i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [15:0]       d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [15:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        arb_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [15:0]       lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              lat_write;
  logic [3:0]        d_streak;

  logic d_req;
  logic i_req;
  logic grant_i;
  logic grant_d;
  logic i_forced;

  assign d_req    = d_pmem_read | d_pmem_write;
  assign i_req    = i_pmem_read;
  assign i_forced = d_streak == 4'(MAX_D_BURST);

  // Next-state and grant decode. Requests are only looked at in IDLE; during
  // service the requester inputs are deliberately ignored.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (d_req && i_req && i_forced) begin
          grant_i   = 1'b1;
          state_nxt = SERVE_I;
        end else if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = SERVE_D;
        end else if (i_req) begin
          grant_i   = 1'b1;
          state_nxt = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        // Returning to IDLE for one cycle drops the pmem command between
        // transactions and lets the finished requester deassert before the
        // next arbitration.
        if (pmem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The latched transaction is reset as well as the state, so the physical
  // memory port reads all-zero immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      d_streak  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
      if (grant_d) begin
        lat_addr  <= d_pmem_address;
        // Write wins when the D-cache raises read and write together.
        lat_write <= d_pmem_write;
        lat_wdata <= d_pmem_write ? d_pmem_wdata : '0;
        if (!i_req)                d_streak <= '0;
        else if (d_streak != 4'hf) d_streak <= d_streak + 4'd1;
      end else if (grant_i) begin
        lat_addr  <= i_pmem_address;
        lat_write <= 1'b0;
        lat_wdata <= '0;
        d_streak  <= '0;
      end
    end
  end

  // Memory command comes purely from registers, never from live request
  // inputs. Response routing is combinational in the pmem_resp cycle.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    i_pmem_rdata = '0;
    d_pmem_rdata = '0;
    if (state != IDLE) begin
      pmem_read    = !lat_write;
      pmem_write   = lat_write;
      pmem_address = lat_addr;
      pmem_wdata   = lat_wdata;
    end
    if (state == SERVE_I && pmem_resp) begin
      i_pmem_resp  = 1'b1;
      i_pmem_rdata = pmem_rdata;
    end
    if (state == SERVE_D && pmem_resp) begin
      d_pmem_resp  = 1'b1;
      d_pmem_rdata = pmem_rdata;
    end
  end

  assign arb_state = state;

endmodule

// File: tb/tb_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmem_arbiter
//
// Directed bench for pmem_arbiter. Each test pushes the memory transactions it
// expects (order, op, address, data, idle gap) and the responses it expects
// (which cache, which data) into queues. Independent monitors pop and compare
// whenever a new pmem command starts or a *_pmem_resp fires. A simple memory
// model answers after mem_lat cycles with data derived from the address.
// -----------------------------------------------------------------------------
module tb_pmem_arbiter;

  localparam int LINE_W = 128;

  typedef struct {
    logic              wr;
    logic [15:0]       addr;
    logic [LINE_W-1:0] wdata;
    int                gap;   // exact idle cycles before this command, -1 = any
  } txn_t;

  typedef struct {
    logic              is_d;
    logic [LINE_W-1:0] data;
  } resp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_pmem_read = 1'b0;
  logic [15:0]       i_pmem_address = '0;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read = 1'b0;
  logic              d_pmem_write = 1'b0;
  logic [15:0]       d_pmem_address = '0;
  logic [LINE_W-1:0] d_pmem_wdata = '0;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [15:0]       pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [1:0]        arb_state;

  // Memory model and manual pulse share the pmem_resp wire.
  logic              model_resp = 1'b0;
  logic              manual_resp = 1'b0;
  logic [LINE_W-1:0] model_rdata = '0;
  logic              mem_en = 1'b1;
  int                mem_lat = 3;
  logic              ovr_en = 1'b0;
  logic [LINE_W-1:0] ovr_data = '0;

  assign pmem_resp  = model_resp | manual_resp;
  assign pmem_rdata = model_rdata;

  int checks   = 0;
  int failures = 0;

  txn_t  txn_q[$];
  resp_t resp_q[$];

  localparam logic [LINE_W-1:0] DEADBEEF = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [LINE_W-1:0] FIVES    = {16{8'h55}};

  pmem_arbiter #(.MAX_D_BURST(4), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp),
    .arb_state      (arb_state)
  );

  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] line_of(input logic [15:0] a);
    return {8{a}};
  endfunction

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_txn(input logic wr, input logic [15:0] a,
                          input logic [LINE_W-1:0] wd, input int gap);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = wd; t.gap = gap;
    txn_q.push_back(t);
  endtask

  task automatic push_resp(input logic is_d, input logic [LINE_W-1:0] data);
    resp_t r;
    r.is_d = is_d; r.data = data;
    resp_q.push_back(r);
  endtask

  // Wait (bounded) for a negedge where the selected signal is high.
  // 0: pmem_read, 1: i_pmem_resp, 2: d_pmem_resp
  task automatic wait_sig(input string name, input int sel);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((sel == 0 && pmem_read) || (sel == 1 && i_pmem_resp) ||
          (sel == 2 && d_pmem_resp))
        return;
    end
    checks++;
    failures++;
    $display("FAIL %s: timeout after 100 cycles, got no event expected event", name);
  endtask

  // Memory model: answers in the mem_lat-th cycle of a command.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en && (pmem_read || pmem_write) && !model_resp) begin
        cnt++;
        if (cnt == mem_lat) begin
          model_resp  = 1'b1;
          model_rdata = ovr_en ? ovr_data : line_of(pmem_address);
        end
      end else begin
        cnt         = 0;
        model_resp  = 1'b0;
        model_rdata = '0;
      end
    end
  end

  // Transaction monitor: order/op/address/data/gap on each new command, and
  // address stability on every cycle of service.
  initial begin
    logic        prev_act;
    logic [15:0] cur_addr;
    int          idle_cnt;
    txn_t        t;
    prev_act = 1'b0;
    cur_addr = '0;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if ((pmem_read || pmem_write) && !prev_act) begin
        if (txn_q.size() == 0) begin
          check("unexpected_cmd", {127'd0, 1'b1}, '0);
        end else begin
          t = txn_q.pop_front();
          check("cmd_write", {127'd0, pmem_write}, {127'd0, t.wr});
          check("cmd_read", {127'd0, pmem_read}, {127'd0, !t.wr});
          check("cmd_addr", {112'd0, pmem_address}, {112'd0, t.addr});
          check("cmd_wdata", pmem_wdata, t.wdata);
          if (t.gap >= 0) check("cmd_idle_gap", LINE_W'(idle_cnt), LINE_W'(t.gap));
        end
        cur_addr = pmem_address;
      end else if (pmem_read || pmem_write) begin
        check("addr_stable", {112'd0, pmem_address}, {112'd0, cur_addr});
      end
      if (pmem_read || pmem_write) idle_cnt = 0;
      else                         idle_cnt++;
      prev_act = pmem_read || pmem_write;
    end
  end

  // Response monitor: routing, data, no cross-delivery.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (i_pmem_resp && d_pmem_resp) begin
        check("both_resp", {127'd0, 1'b1}, '0);
      end else if (i_pmem_resp || d_pmem_resp) begin
        if (resp_q.size() == 0) begin
          check("unexpected_resp", {127'd0, 1'b1}, '0);
        end else begin
          r = resp_q.pop_front();
          check("resp_is_d", {127'd0, d_pmem_resp}, {127'd0, r.is_d});
          if (d_pmem_resp) begin
            check("d_rdata", d_pmem_rdata, r.data);
            check("i_rdata_idle", i_pmem_rdata, '0);
          end else begin
            check("i_rdata", i_pmem_rdata, r.data);
            check("d_rdata_idle", d_pmem_rdata, '0);
          end
        end
      end
    end
  end

  task automatic i_txn(input logic [15:0] a, input bit lat_chk);
    i_pmem_read    = 1'b1;
    i_pmem_address = a;
    if (lat_chk) begin
      @(posedge clk);
      @(negedge clk);
      check("i_lat_read", {127'd0, pmem_read}, {127'd0, 1'b1});
      check("i_lat_addr", {112'd0, pmem_address}, {112'd0, a});
    end
    wait_sig("i_resp_wait", 1);
    @(posedge clk);
    #1;
    i_pmem_read = 1'b0;
  endtask

  task automatic d_txn(input logic wr, input logic [15:0] a,
                       input logic [LINE_W-1:0] wd, input bit keep);
    d_pmem_read    = !wr;
    d_pmem_write   = wr;
    d_pmem_address = a;
    d_pmem_wdata   = wd;
    wait_sig("d_resp_wait", 2);
    @(posedge clk);
    #1;
    if (!keep) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end
  endtask

  initial begin
    // Reset state, asserted from time 0.
    #3;
    check("rst_pmem_read", {127'd0, pmem_read}, '0);
    check("rst_pmem_write", {127'd0, pmem_write}, '0);
    check("rst_pmem_address", {112'd0, pmem_address}, '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_resp", {126'd0, i_pmem_resp, d_pmem_resp}, '0);
    check("rst_arb_state", {126'd0, arb_state}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single I read, 3-cycle memory, override data.
    mem_lat  = 3;
    ovr_en   = 1'b1;
    ovr_data = DEADBEEF;
    push_txn(1'b0, 16'h1230, '0, -1);
    push_resp(1'b0, DEADBEEF);
    i_txn(16'h1230, 1'b1);
    ovr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Simultaneous I read and D write: D first, one idle cycle, then I.
    mem_lat = 2;
    push_txn(1'b1, 16'h2000, FIVES, -1);
    push_txn(1'b0, 16'h0100, '0, 1);
    push_resp(1'b1, line_of(16'h2000));
    push_resp(1'b0, line_of(16'h0100));
    fork
      i_txn(16'h0100, 1'b0);
      d_txn(1'b1, 16'h2000, FIVES, 1'b0);
    join
    repeat (2) @(posedge clk);
    #1;

    // Starvation: 4 D reads, forced I, then D again.
    mem_lat = 1;
    for (int k = 0; k < 4; k++) begin
      push_txn(1'b0, 16'h0800 + 16'(k), '0, (k == 0) ? -1 : 1);
      push_resp(1'b1, line_of(16'h0800 + 16'(k)));
    end
    push_txn(1'b0, 16'h0040, '0, 1);
    push_resp(1'b0, line_of(16'h0040));
    push_txn(1'b0, 16'h0804, '0, 1);
    push_resp(1'b1, line_of(16'h0804));
    fork
      i_txn(16'h0040, 1'b0);
      begin
        for (int k = 0; k < 4; k++) d_txn(1'b0, 16'h0800 + 16'(k), '0, 1'b1);
        d_txn(1'b0, 16'h0804, '0, 1'b0);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Input instability during service.
    mem_lat = 4;
    push_txn(1'b0, 16'h3000, '0, -1);
    push_resp(1'b1, line_of(16'h3000));
    d_pmem_read    = 1'b1;
    d_pmem_address = 16'h3000;
    wait_sig("unstable_start", 0);
    @(posedge clk);
    #1;
    d_pmem_address = 16'h4000;
    d_pmem_read    = 1'b0;
    wait_sig("unstable_resp", 2);
    repeat (4) @(posedge clk);
    #1;

    // Stray response in IDLE.
    manual_resp = 1'b1;
    @(negedge clk);
    check("stray_i_resp", {127'd0, i_pmem_resp}, '0);
    check("stray_d_resp", {127'd0, d_pmem_resp}, '0);
    check("stray_state", {126'd0, arb_state}, '0);
    @(posedge clk);
    #1;
    manual_resp = 1'b0;
    @(negedge clk);
    check("stray_state_after", {126'd0, arb_state}, '0);

    // Reset mid-write with a late response.
    mem_en = 1'b0;
    @(posedge clk);
    #1;
    push_txn(1'b1, 16'h7000, {8{16'hA5C3}}, -1);
    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h7000;
    d_pmem_wdata   = {8{16'hA5C3}};
    @(posedge clk);
    @(negedge clk);
    check("mid_write_on", {127'd0, pmem_write}, {127'd0, 1'b1});
    check("mid_state_d", {126'd0, arb_state}, {126'd0, 2'b10});
    #2;
    d_pmem_write = 1'b0;
    rst          = 1'b1;
    #1;
    check("async_write_off", {127'd0, pmem_write}, '0);
    check("async_state", {126'd0, arb_state}, '0);
    check("async_addr", {112'd0, pmem_address}, '0);
    manual_resp = 1'b1;
    #1;
    check("late_resp_in_rst", {127'd0, d_pmem_resp}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("late_resp_post_rst", {127'd0, d_pmem_resp}, '0);
    check("post_rst_state", {126'd0, arb_state}, '0);
    @(posedge clk);
    #1;
    manual_resp = 1'b0;
    mem_en      = 1'b1;
    repeat (4) @(posedge clk);

    check("txn_q_drained", LINE_W'(txn_q.size()), '0);
    check("resp_q_drained", LINE_W'(resp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
